hc_sr04_scheduler: RTL and testbench



---
 rtl/hc_sr04_scheduler.sv | 151 +++++++++++++++
 tb/tb_hc_sr04_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_scheduler.sv
// Round-robin scheduler sharing one HC-SR04 measurement engine across n_sensors rangers.
// Each slot: trig pulse, echo timing in centimetres, result published to a per-sensor bank.
module hc_sr04_scheduler #(
  parameter int unsigned clk_frequency   = 50000000,
  parameter int unsigned n_sensors       = 4,
  parameter int unsigned distance_width  = 8,
  parameter int unsigned slot_time_ms    = 60,
  parameter int unsigned trig_time_us    = 10,
  parameter int unsigned rise_timeout_ms = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 enable,
  output logic [n_sensors-1:0]                                 trig,
  input  logic [n_sensors-1:0]                                 echo,
  output logic [n_sensors*distance_width-1:0]                  distance,
  output logic [n_sensors-1:0]                                 valid,
  output logic [n_sensors-1:0]                                 timeout,
  output logic                                                 busy,
  output logic [((n_sensors > 1) ? $clog2(n_sensors) : 1)-1:0] cur_sensor
);

  localparam int unsigned NS          = n_sensors;
  localparam int unsigned DW          = distance_width;
  localparam int unsigned SLOT_CYCLES = 32'(64'(slot_time_ms) * 64'(clk_frequency) / 64'd1000);
  localparam int unsigned TRIG_CYCLES = 32'(64'(trig_time_us) * 64'(clk_frequency) / 64'd1000000);
  localparam int unsigned RISE_CYCLES = 32'(64'(rise_timeout_ms) * 64'(clk_frequency) / 64'd1000);
  localparam int unsigned CM_CYCLES   = 32'(64'(clk_frequency) * 64'd2 / 64'd343 / 64'd100);
  localparam int unsigned CSW         = (n_sensors > 1) ? $clog2(n_sensors) : 1;
  localparam int unsigned SCW         = $clog2(SLOT_CYCLES + 1);
  localparam int unsigned WCW         = $clog2(RISE_CYCLES + 1);
  localparam int unsigned PSW         = $clog2(CM_CYCLES + 1);

  localparam logic [SCW-1:0] TRIG_LAST = SCW'(TRIG_CYCLES - 1);
  localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RISE_CYCLES - 1);
  localparam logic [PSW-1:0] PRE_LAST  = PSW'(CM_CYCLES - 1);
  localparam logic [CSW-1:0] CUR_LAST  = CSW'(n_sensors - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  logic [2:0]     state, state_next;
  logic [NS-1:0]  sync1, sync2, echo_q;
  logic [SCW-1:0] slot_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [PSW-1:0] pre_cnt;
  logic [DW-1:0]  cm_cnt;
  logic [CSW-1:0] cur_next;
  logic           rise_c, fall_c, slot_last_c;
  logic           done_c, fail_c, advance_c;

  // Edges of the selected sensor's synchronised echo only
  assign rise_c      = sync2[cur_sensor] & ~echo_q[cur_sensor];
  assign fall_c      = ~sync2[cur_sensor] & echo_q[cur_sensor];
  assign slot_last_c = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and slot events; a result landing on the last slot cycle advances at once
  // so the following trig keeps its exact slot spacing.
  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    fail_c     = 1'b0;
    advance_c  = 1'b0;
    cur_next   = cur_sensor;
    case (state)
      IDLE:      if (enable) state_next = TRIG;
      TRIG:      if (slot_cnt == TRIG_LAST) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (rise_c)                     state_next = MEASURE;
        else if (wait_cnt == WAIT_LAST) fail_c = 1'b1;
      end
      MEASURE: begin
        if (fall_c)           done_c = 1'b1;
        else if (slot_last_c) fail_c = 1'b1;
      end
      GAP:     advance_c = slot_last_c;
      default: state_next = IDLE;
    endcase
    if (done_c || fail_c) begin
      if (slot_last_c) advance_c = 1'b1;
      else             state_next = GAP;
    end
    if (advance_c) begin
      state_next = enable ? TRIG : IDLE;
      cur_next   = (cur_sensor == CUR_LAST) ? '0 : cur_sensor + CSW'(1);
    end
  end

  // Synchronisers, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      echo_q     <= '0;
      slot_cnt   <= '0;
      wait_cnt   <= '0;
      pre_cnt    <= '0;
      cm_cnt     <= '0;
      trig       <= '0;
      distance   <= '0;
      valid      <= '0;
      timeout    <= '0;
      busy       <= 1'b0;
      cur_sensor <= '0;
    end else begin
      sync1      <= echo;
      sync2      <= sync1;
      echo_q     <= sync2;
      trig       <= (state_next == TRIG) ? (NS'(1) << cur_next) : '0;
      busy       <= (state_next != IDLE);
      cur_sensor <= cur_next;
      valid      <= '0;

      if (state_next == TRIG && state != TRIG) slot_cnt <= '0;
      else if (state != IDLE)                  slot_cnt <= slot_cnt + SCW'(1);

      if (state == WAIT_RISE) wait_cnt <= wait_cnt + WCW'(1);
      else                    wait_cnt <= '0;

      if (state != MEASURE) begin
        pre_cnt <= '0;
        cm_cnt  <= '0;
      end else if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        if (cm_cnt != '1) cm_cnt <= cm_cnt + DW'(1);
      end else begin
        pre_cnt <= pre_cnt + PSW'(1);
      end

      if (done_c) begin
        distance[int'(cur_sensor)*DW +: DW] <= cm_cnt;
        valid[cur_sensor]                   <= 1'b1;
        timeout[cur_sensor]                 <= 1'b0;
      end else if (fail_c) begin
        distance[int'(cur_sensor)*DW +: DW] <= '1;
        valid[cur_sensor]                   <= 1'b1;
        timeout[cur_sensor]                 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hc_sr04_scheduler.sv
// Randomised bench for hc_sr04_scheduler: two sensors, a shortened slot and a 6-bit result
// so saturation and slot overrun fit a short run.
module tb_hc_sr04_scheduler;

  localparam int NS    = 2;
  localparam int DW    = 6;
  localparam int SLOT  = 4000;
  localparam int TRIGC = 10;
  localparam int RISE  = 1000;
  localparam int CMC   = 58;
  localparam logic [DW-1:0] DMAX = 6'h3f;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NS-1:0]     trig;
  logic [NS-1:0]     echo = '0;
  logic [NS*DW-1:0]  distance;
  logic [NS-1:0]     valid;
  logic [NS-1:0]     timeout;
  logic              busy;
  logic [0:0]        cur_sensor;

  hc_sr04_scheduler #(
    .clk_frequency(1000000), .n_sensors(NS), .distance_width(DW),
    .slot_time_ms(4), .trig_time_us(10), .rise_timeout_ms(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig), .echo(echo),
    .distance(distance), .valid(valid), .timeout(timeout), .busy(busy),
    .cur_sensor(cur_sensor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observation of trig pulses and valid pulses, independent of the stimulus tasks
  int rise_n[NS] = '{0, 0};
  int rise_t[NS] = '{0, 0};
  int hi_cnt[NS] = '{0, 0};
  int width_last[NS] = '{0, 0};
  int valid_n[NS] = '{0, 0};
  int multi_valid = 0;
  int multi_trig = 0;
  logic [NS-1:0] trig_q = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (trig[i] && !trig_q[i]) begin
        rise_n[i]++;
        rise_t[i] = cyc;
        hi_cnt[i] = 0;
      end
      if (trig[i]) hi_cnt[i]++;
      else if (trig_q[i]) width_last[i] = hi_cnt[i];
      if (valid[i]) valid_n[i]++;
    end
    if ($countones(valid) > 1) multi_valid++;
    if ($countones(trig) > 1) multi_trig++;
    trig_q = trig;
  end

  int nxt = 0;
  int seen_n[NS] = '{0, 0};
  int prev_rise = 0;
  int last_t = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One slot on sensor nxt: echo rises offs cycles after trig falls and stays high len
  // cycles (len=0: never rises). Expected result comes from the ranging rules directly.
  task automatic run_slot(input int offs, input int len, input bit contiguous,
                          input bit noise, input bit drop_en);
    int idx, oth, t, tf, tv, d_exp, k, v0, vo0;
    bit got, ovr;
    logic [DW-1:0] d, d_oth0;
    idx = nxt;
    oth = 1 - idx;
    got = 1'b0;
    tv  = 0;
    k   = 0;
    while (rise_n[idx] == seen_n[idx] && k < SLOT + 100) begin tick(); k++; end
    checks++;
    if (rise_n[idx] == seen_n[idx]) begin
      errors++; $display("FAIL trig_rise sensor %0d: no rise after %0d cycles, required one", idx, k);
    end
    seen_n[idx] = rise_n[idx];
    t = rise_t[idx];
    if (contiguous) begin
      checks++;
      if (t - prev_rise !== SLOT) begin
        errors++; $display("FAIL slot_spacing sensor %0d: got %0d cycles, required %0d", idx, t - prev_rise, SLOT);
      end
    end
    prev_rise = t;
    last_t = t;
    checks++;
    if (cur_sensor !== 1'(idx)) begin
      errors++; $display("FAIL cur_sensor: got %0d, required %0d", cur_sensor, idx);
    end
    k = 0;
    while (trig[idx] === 1'b1 && k < 50) begin tick(); k++; end
    tf = cyc;
    checks++;
    if (width_last[idx] !== TRIGC) begin
      errors++; $display("FAIL trig_width sensor %0d: got %0d, required %0d", idx, width_last[idx], TRIGC);
    end
    v0 = valid_n[idx];
    vo0 = valid_n[oth];
    d_oth0 = distance[oth*DW +: DW];
    fork
      begin
        if (len > 0) begin
          repeat (offs) tick();
          echo[idx] = 1'b1;
          for (int i = 0; i < len; i++) begin
            if (got) break;
            tick();
            if (drop_en && i == 100) enable = 1'b0;
          end
          echo[idx] = 1'b0;
        end
      end
      begin
        for (int i = 0; i < SLOT + 200; i++) begin
          tick();
          if (valid_n[idx] != v0) begin got = 1'b1; tv = cyc; break; end
        end
      end
      begin
        if (noise) begin
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(10, 60)) tick();
            echo[oth] = ~echo[oth];
          end
          echo[oth] = 1'b0;
        end
      end
    join
    repeat (5) tick();
    checks++;
    if (!got) begin
      errors++; $display("FAIL valid_missing sensor %0d: no valid pulse, required one", idx);
    end
    checks++;
    if (valid_n[idx] !== v0 + 1) begin
      errors++; $display("FAIL valid_count sensor %0d: got %0d pulses, required 1", idx, valid_n[idx] - v0);
    end
    if (noise) begin
      checks++;
      if (valid_n[oth] !== vo0 || distance[oth*DW +: DW] !== d_oth0) begin
        errors++; $display("FAIL ignore_other: valid pulses %0d dist %0d, required 0 pulses dist %0d",
                           valid_n[oth] - vo0, distance[oth*DW +: DW], d_oth0);
      end
    end
    ovr = (len > 0) && (TRIGC + offs + len + 5 >= SLOT);
    d = distance[idx*DW +: DW];
    if (len == 0 || ovr) begin
      checks++;
      if (d !== DMAX) begin
        errors++; $display("FAIL fail_distance sensor %0d: got %0d, required %0d", idx, d, DMAX);
      end
      checks++;
      if (timeout[idx] !== 1'b1) begin
        errors++; $display("FAIL fail_timeout sensor %0d: got %b, required 1", idx, timeout[idx]);
      end
      checks++;
      if (len == 0 && (tv - tf < RISE - 2 || tv - tf > RISE + 2)) begin
        errors++; $display("FAIL rise_timeout_time: got %0d cycles after trig fall, required %0d", tv - tf, RISE);
      end else if (len != 0 && (tv - t < SLOT - 1 || tv - t > SLOT + 1)) begin
        errors++; $display("FAIL overrun_time: got %0d cycles after trig rise, required %0d", tv - t, SLOT);
      end
    end else begin
      d_exp = len / CMC;
      if (d_exp > 63) d_exp = 63;
      checks++;
      if (int'(d) < d_exp - 1 || int'(d) > d_exp + 1) begin
        errors++; $display("FAIL distance sensor %0d: got %0d, required %0d +/-1", idx, d, d_exp);
      end
      checks++;
      if (timeout[idx] !== 1'b0) begin
        errors++; $display("FAIL good_timeout sensor %0d: got %b, required 0", idx, timeout[idx]);
      end
    end
    nxt = oth;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (trig !== '0 || valid !== '0 || distance !== '0 || timeout !== '0 || busy !== 1'b0 || cur_sensor !== 1'b0) begin
      errors++; $display("FAIL reset_values: trig=%b valid=%b dist=%h timeout=%b busy=%b cur=%0d, required all 0",
                         trig, valid, distance, timeout, busy, cur_sensor);
    end
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || trig !== '0 || rise_n[0] + rise_n[1] != 0) begin
      errors++; $display("FAIL idle_hold: busy=%b trig=%b rises=%0d, required idle with no trig",
                         busy, trig, rise_n[0] + rise_n[1]);
    end
  endtask

  task automatic test_rotation();
    enable = 1'b1;
    run_slot(0, 0, 1'b0, 1'b0, 1'b0);
    run_slot(0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (timeout !== 2'b11) begin
      errors++; $display("FAIL both_timeouts: got %b, required 11", timeout);
    end
    run_slot(100, CMC * 25, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_measure();
    int k, offs;
    for (int n = 0; n < 3; n++) begin
      k = $urandom_range(1, 50);
      offs = $urandom_range(5, 800);
      run_slot(offs, k * CMC + $urandom_range(0, 57), 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (timeout !== 2'b00) begin
      errors++; $display("FAIL timeout_cleared: got %b, required 00", timeout);
    end
  endtask

  task automatic test_saturate();
    run_slot(20, CMC * 66, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    run_slot(30, 6000, 1'b1, 1'b0, 1'b0);
    run_slot(50, CMC * 10, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignore();
    run_slot(40, CMC * 30, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_enable_drop();
    int k, r0;
    run_slot(60, CMC * 20, 1'b1, 1'b0, 1'b1);
    k = 0;
    while (busy === 1'b1 && k < SLOT) begin tick(); k++; end
    checks++;
    if (cyc - last_t < SLOT - 1 || cyc - last_t > SLOT + 1) begin
      errors++; $display("FAIL busy_fall: got %0d cycles after trig rise, required %0d", cyc - last_t, SLOT);
    end
    r0 = rise_n[0] + rise_n[1];
    repeat (SLOT + 500) tick();
    checks++;
    if (rise_n[0] + rise_n[1] != r0 || busy !== 1'b0 || cur_sensor !== 1'b1) begin
      errors++; $display("FAIL stays_idle: new rises %0d busy=%b cur=%0d, required 0, 0, 1",
                         rise_n[0] + rise_n[1] - r0, busy, cur_sensor);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    enable = 1'b1;
    k = 0;
    while (rise_n[nxt] == seen_n[nxt] && k < 100) begin tick(); k++; end
    seen_n[nxt] = rise_n[nxt];
    checks++;
    if (cur_sensor !== 1'(nxt) || trig[nxt] !== 1'b1) begin
      errors++; $display("FAIL resume_slot: cur=%0d trig=%b, required cur %0d with its trig high", cur_sensor, trig, nxt);
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (trig !== '0 || valid !== '0 || distance !== '0 || timeout !== '0 || busy !== 1'b0 || cur_sensor !== 1'b0) begin
      errors++; $display("FAIL reset_mid: trig=%b valid=%b dist=%h timeout=%b busy=%b cur=%0d, required all 0",
                         trig, valid, distance, timeout, busy, cur_sensor);
    end
    repeat (3) tick();
    rst = 1'b0;
    nxt = 0;
    run_slot(100, CMC * 12, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_invariants();
    checks++;
    if (multi_valid != 0 || multi_trig != 0) begin
      errors++; $display("FAIL onehot: multi-valid cycles %0d multi-trig cycles %0d, required 0 and 0",
                         multi_valid, multi_trig);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_random_measure();
    test_saturate();
    test_overrun();
    test_ignore();
    test_enable_drop();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
